// File: rtl/wb_pkg.sv
// Shared writeback-control types and RV32I opcode constants for the rv32 core.
package wb_pkg;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] FENCE  = 7'b0001111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [1:0] sel;
    logic [4:0] rd;
  } wb_ctl_t;

  localparam wb_ctl_t CTL_BUBBLE = '{valid: 1'b0, we: 1'b0, sel: WB_MEM, rd: 5'd0};

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OP) || (opc == BRANCH) || (opc == STORE);
  endfunction

  // Only loads write back from memory, so a writing MEM-select entry is a load.
  function automatic logic is_load(input wb_ctl_t c);
    return c.valid & c.we & (c.sel == WB_MEM);
  endfunction

endpackage

// File: rtl/wb_decode.sv
// Combinational RV32I decoder: instruction to writeback control plus illegal flag.
module wb_decode
  import wb_pkg::*;
(
  input  logic [31:0] instruction,
  output wb_ctl_t     ctl,
  output logic        illegal
);

  logic [6:0] opc_s;
  logic [2:0] f3_s;
  logic [6:0] f7_s;
  logic [4:0] rd_s;
  logic       legal_s;
  logic       we_s;
  logic [1:0] sel_s;

  assign opc_s = instruction[6:0];
  assign f3_s  = instruction[14:12];
  assign f7_s  = instruction[31:25];
  assign rd_s  = instruction[11:7];

  // Legality and raw writeback control per opcode.
  always_comb begin
    legal_s = 1'b0;
    we_s    = 1'b0;
    sel_s   = WB_MEM;
    case (opc_s)
      LUI, AUIPC: begin
        legal_s = 1'b1;
        we_s    = 1'b1;
        sel_s   = WB_ALU;
      end
      JAL: begin
        legal_s = 1'b1;
        we_s    = 1'b1;
        sel_s   = WB_PC4;
      end
      JALR: begin
        legal_s = (f3_s == 3'b000);
        we_s    = 1'b1;
        sel_s   = WB_PC4;
      end
      LOAD: begin
        we_s  = 1'b1;
        sel_s = WB_MEM;
        case (f3_s)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_s = 1'b1;
          default:                                legal_s = 1'b0;
        endcase
      end
      OP_IMM: begin
        we_s  = 1'b1;
        sel_s = WB_ALU;
        case (f3_s)
          3'b001:  legal_s = (f7_s == 7'b0000000);
          3'b101:  legal_s = (f7_s == 7'b0000000) || (f7_s == 7'b0100000);
          default: legal_s = 1'b1;
        endcase
      end
      OP: begin
        we_s    = 1'b1;
        sel_s   = WB_ALU;
        legal_s = (f7_s == 7'b0000000) ||
                  ((f7_s == 7'b0100000) && ((f3_s == 3'b000) || (f3_s == 3'b101)));
      end
      BRANCH:  legal_s = (f3_s != 3'b010) && (f3_s != 3'b011);
      STORE:   legal_s = (f3_s <= 3'b010);
      FENCE:   legal_s = 1'b1;
      SYSTEM:  legal_s = (instruction == 32'h0000_0073) || (instruction == 32'h0010_0073);
      default: legal_s = 1'b0;
    endcase
  end

  assign illegal = ~legal_s;
  assign ctl = '{valid: legal_s,
                 we:    legal_s & we_s & (rd_s != 5'd0),
                 sel:   legal_s ? sel_s : WB_MEM,
                 rd:    legal_s ? rd_s : 5'd0};

endmodule

// File: rtl/wb_ctl_pipe.sv
// Writeback-control pipeline: decode at issue, STAGES control registers with
// stall/flush, load-use detection, illegal pulse and retire counter.
module wb_ctl_pipe
  import wb_pkg::*;
#(
  parameter int STAGES      = 3,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [31:0]           instruction,
  input  logic                  stall,
  input  logic                  flush,
  output logic [STAGES-1:0]     stage_valid,
  output logic [5*STAGES-1:0]   stage_rd,
  output logic [STAGES-1:0]     stage_we,
  output logic                  wb_valid,
  output logic [1:0]            wb_sel,
  output logic                  wb_we,
  output logic [4:0]            wb_rd,
  output logic                  load_use,
  output logic                  illegal,
  output logic [CNT_W-1:0]      retire_cnt
);

  wb_ctl_t          dec_ctl_s;
  logic             dec_illegal_s;
  logic             issue_s;
  wb_ctl_t          issue_ctl_s;
  wb_ctl_t          s0_s;
  wb_ctl_t          last_s;
  logic             illegal_q;
  logic [CNT_W-1:0] retire_q;

  wb_decode u_decode (
    .instruction (instruction),
    .ctl         (dec_ctl_s),
    .illegal     (dec_illegal_s)
  );

  assign issue_s     = in_valid & ~stall & ~flush;
  assign issue_ctl_s = issue_s ? dec_ctl_s : CTL_BUBBLE;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    wb_ctl_t ctl_q;
    wb_ctl_t ctl_d;
    wb_ctl_t src_s;

    if (k == 0) begin : g_src_issue
      assign src_s = issue_ctl_s;
    end else begin : g_src_prev
      assign src_s = g_stage[k-1].ctl_q;
    end

    // Flush kills the youngest stages; older stages keep advancing even under stall.
    always_comb begin
      if (flush && (k < FLUSH_DEPTH)) begin
        ctl_d = CTL_BUBBLE;
      end else if (flush || !stall) begin
        ctl_d = src_s;
      end else begin
        ctl_d = ctl_q;
      end
    end

    // Stage control register.
    always_ff @(posedge clk) begin
      if (!rst) begin
        ctl_q <= CTL_BUBBLE;
      end else begin
        ctl_q <= ctl_d;
      end
    end

    assign stage_valid[k]      = ctl_q.valid;
    assign stage_we[k]         = ctl_q.we;
    assign stage_rd[5*k +: 5]  = ctl_q.rd;
  end

  assign s0_s   = g_stage[0].ctl_q;
  assign last_s = g_stage[STAGES-1].ctl_q;

  assign wb_valid = last_s.valid;
  assign wb_sel   = last_s.sel;
  assign wb_we    = last_s.valid & last_s.we;
  assign wb_rd    = last_s.rd;

  assign load_use = in_valid & is_load(s0_s) & (s0_s.rd != 5'd0) &
                    ((instruction[19:15] == s0_s.rd) |
                     (uses_rs2(instruction[6:0]) & (instruction[24:20] == s0_s.rd)));

  // Illegal-issue pulse and retire counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      illegal_q <= 1'b0;
      retire_q  <= {CNT_W{1'b0}};
    end else begin
      illegal_q <= issue_s & dec_illegal_s;
      if (wb_valid & wb_we) begin
        retire_q <= retire_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        retire_q <= retire_q;
      end
    end
  end

  assign illegal    = illegal_q;
  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_wb_ctl_pipe.sv
// Self-checking bench for wb_ctl_pipe: vector table with a writeback scoreboard,
// plus hand sequences for stall, flush, counter wrap and mid-stream reset.
module tb_wb_ctl_pipe;

  localparam int STAGES = 3;
  localparam int FD     = 2;
  localparam int CNT_W  = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic [31:0]         instruction;
  logic                stall;
  logic                flush;
  logic [STAGES-1:0]   stage_valid;
  logic [5*STAGES-1:0] stage_rd;
  logic [STAGES-1:0]   stage_we;
  logic                wb_valid;
  logic [1:0]          wb_sel;
  logic                wb_we;
  logic [4:0]          wb_rd;
  logic                load_use;
  logic                illegal;
  logic [CNT_W-1:0]    retire_cnt;

  wb_ctl_pipe #(.STAGES(STAGES), .FLUSH_DEPTH(FD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction),
    .stall(stall), .flush(flush), .stage_valid(stage_valid), .stage_rd(stage_rd),
    .stage_we(stage_we), .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_we(wb_we),
    .wb_rd(wb_rd), .load_use(load_use), .illegal(illegal), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        iv;
    logic        v;
    logic [1:0]  sel;
    logic        we;
    logic [4:0]  rd;
    logic        ill;
    logic        lu;
  } vec_t;

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic       we;
    logic [4:0] rd;
  } wbexp_t;

  wbexp_t           exp_q[$];
  vec_t             tbl[34];
  int               n_pass = 0;
  int               n_tot  = 0;
  logic [CNT_W-1:0] cnt_model;
  logic [CNT_W-1:0] start_cnt;

  function automatic vec_t mk(input logic [31:0] i, input logic iv, input logic v,
                              input logic [1:0] sel, input logic we, input logic [4:0] rd,
                              input logic ill, input logic lu);
    vec_t r;
    r.instr = i; r.iv = iv; r.v = v; r.sel = sel; r.we = we; r.rd = rd; r.ill = ill; r.lu = lu;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cycle(input vec_t v);
    wbexp_t e;
    in_valid = v.iv; instruction = v.instr; stall = 1'b0; flush = 1'b0;
    #1;
    chk("load_use", 32'(load_use), 32'(v.lu));
    e = '{v.v, v.sel, v.we, v.rd};
    exp_q.push_back(e);
    @(posedge clk); #1;
    chk("illegal", 32'(illegal), 32'(v.ill));
    chk("retire_cnt", 32'(retire_cnt), 32'(cnt_model));
    if (exp_q.size() == STAGES) begin
      e = exp_q.pop_front();
      chk("wb_valid", 32'(wb_valid), 32'(e.v));
      chk("wb_sel",   32'(wb_sel),   32'(e.sel));
      chk("wb_we",    32'(wb_we),    32'(e.we));
      chk("wb_rd",    32'(wb_rd),    32'(e.rd));
      if (e.v && e.we) cnt_model++;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_stage_valid"}, 32'(stage_valid), 32'd0);
    chk({tag, "_stage_rd"},    32'(stage_rd),    32'd0);
    chk({tag, "_stage_we"},    32'(stage_we),    32'd0);
    chk({tag, "_wb_valid"},    32'(wb_valid),    32'd0);
    chk({tag, "_wb_sel"},      32'(wb_sel),      32'd0);
    chk({tag, "_wb_we"},       32'(wb_we),       32'd0);
    chk({tag, "_wb_rd"},       32'(wb_rd),       32'd0);
    chk({tag, "_illegal"},     32'(illegal),     32'd0);
    chk({tag, "_retire_cnt"},  32'(retire_cnt),  32'd0);
    chk({tag, "_load_use"},    32'(load_use),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t bub;
    vec_t addi5;
    bub   = mk(32'h0000_0000, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
    addi5 = mk(32'h0010_0293, 1'b1, 1'b1, 2'b01, 1'b1, 5'd5, 1'b0, 1'b0);

    rst = 1'b0; in_valid = 1'b0; instruction = 32'h0; stall = 1'b0; flush = 1'b0;
    cnt_model = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;

    //              instr          iv    v     sel    we    rd     ill   lu
    tbl[0]  = mk(32'h0010_0293, 1'b1, 1'b1, 2'b01, 1'b1, 5'd5,  1'b0, 1'b0); // ADDI x5
    tbl[1]  = mk(32'h0000_80E7, 1'b1, 1'b1, 2'b10, 1'b1, 5'd1,  1'b0, 1'b0); // JALR x1
    tbl[2]  = mk(32'h0051_2023, 1'b1, 1'b1, 2'b00, 1'b0, 5'd0,  1'b0, 1'b0); // SW x5
    tbl[3]  = mk(32'h0000_A383, 1'b1, 1'b1, 2'b00, 1'b1, 5'd7,  1'b0, 1'b0); // LW x7
    tbl[4]  = mk(32'h0033_8433, 1'b1, 1'b1, 2'b01, 1'b1, 5'd8,  1'b0, 1'b1); // ADD x8,x7,x3
    tbl[5]  = mk(32'h0000_A303, 1'b1, 1'b1, 2'b00, 1'b1, 5'd6,  1'b0, 1'b0); // LW x6
    tbl[6]  = mk(32'h0070_0433, 1'b1, 1'b1, 2'b01, 1'b1, 5'd8,  1'b0, 1'b0); // ADD x8,x0,x7
    tbl[7]  = mk(32'h0000_A383, 1'b1, 1'b1, 2'b00, 1'b1, 5'd7,  1'b0, 1'b0); // LW x7
    tbl[8]  = mk(32'h0071_2023, 1'b1, 1'b1, 2'b00, 1'b0, 5'd0,  1'b0, 1'b1); // SW x7 (rs2 hit)
    tbl[9]  = mk(32'h0000_A383, 1'b1, 1'b1, 2'b00, 1'b1, 5'd7,  1'b0, 1'b0); // LW x7
    tbl[10] = mk(32'h0070_0093, 1'b1, 1'b1, 2'b01, 1'b1, 5'd1,  1'b0, 1'b0); // ADDI x1,x0,7
    tbl[11] = mk(32'h0000_A383, 1'b1, 1'b1, 2'b00, 1'b1, 5'd7,  1'b0, 1'b0); // LW x7
    tbl[12] = mk(32'h0033_8433, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0,  1'b0, 1'b0); // no in_valid
    tbl[13] = mk(32'h0000_2003, 1'b1, 1'b1, 2'b00, 1'b0, 5'd0,  1'b0, 1'b0); // LW x0
    tbl[14] = mk(32'h0000_00B3, 1'b1, 1'b1, 2'b01, 1'b1, 5'd1,  1'b0, 1'b0); // ADD x1,x0,x0
    tbl[15] = mk(32'h4020_84B3, 1'b1, 1'b1, 2'b01, 1'b1, 5'd9,  1'b0, 1'b0); // SUB x9
    tbl[16] = mk(32'h4000_24B3, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0,  1'b1, 1'b0); // SLT f7=0100000
    tbl[17] = mk(32'h1234_5537, 1'b1, 1'b1, 2'b01, 1'b1, 5'd10, 1'b0, 1'b0); // LUI x10
    tbl[18] = mk(32'h0000_1597, 1'b1, 1'b1, 2'b01, 1'b1, 5'd11, 1'b0, 1'b0); // AUIPC x11
    tbl[19] = mk(32'h0080_00EF, 1'b1, 1'b1, 2'b10, 1'b1, 5'd1,  1'b0, 1'b0); // JAL x1
    tbl[20] = mk(32'h0020_8463, 1'b1, 1'b1, 2'b00, 1'b0, 5'd8,  1'b0, 1'b0); // BEQ
    tbl[21] = mk(32'h0020_A463, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0,  1'b1, 1'b0); // branch f3=010
    tbl[22] = mk(32'h0030_9613, 1'b1, 1'b1, 2'b01, 1'b1, 5'd12, 1'b0, 1'b0); // SLLI x12
    tbl[23] = mk(32'h4030_9613, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0,  1'b1, 1'b0); // SLLI bad f7
    tbl[24] = mk(32'h4020_D693, 1'b1, 1'b1, 2'b01, 1'b1, 5'd13, 1'b0, 1'b0); // SRAI x13
    tbl[25] = mk(32'h0000_B383, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0,  1'b1, 1'b0); // LD
    tbl[26] = mk(32'h0000_4703, 1'b1, 1'b1, 2'b00, 1'b1, 5'd14, 1'b0, 1'b0); // LBU x14
    tbl[27] = mk(32'h0000_0073, 1'b1, 1'b1, 2'b00, 1'b0, 5'd0,  1'b0, 1'b0); // ECALL
    tbl[28] = mk(32'h3401_1073, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0,  1'b1, 1'b0); // CSRRW
    tbl[29] = mk(32'h0FF0_000F, 1'b1, 1'b1, 2'b00, 1'b0, 5'd0,  1'b0, 1'b0); // FENCE
    tbl[30] = mk(32'h0051_3023, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0,  1'b1, 1'b0); // store f3=011
    tbl[31] = mk(32'h0000_0013, 1'b1, 1'b1, 2'b01, 1'b0, 5'd0,  1'b0, 1'b0); // NOP
    tbl[32] = mk(32'hFFFF_FFFF, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0,  1'b1, 1'b0); // all ones
    tbl[33] = mk(32'h0010_0073, 1'b1, 1'b1, 2'b00, 1'b0, 5'd0,  1'b0, 1'b0); // EBREAK

    for (int i = 0; i < 34; i++) cycle(tbl[i]);
    repeat (3) cycle(bub);
    exp_q.delete();

    // Sixteen writing retirements bring a 4-bit counter back to its start value.
    start_cnt = cnt_model;
    repeat (16) cycle(addi5);
    repeat (3) cycle(bub);
    exp_q.delete();
    chk("retire_wrap", 32'(retire_cnt), 32'(start_cnt));

    // Fill stages with x1 (oldest), x2, x3, then stall with an illegal word at issue.
    cycle(mk(32'h0010_0093, 1'b1, 1'b1, 2'b01, 1'b1, 5'd1, 1'b0, 1'b0));
    cycle(mk(32'h0010_0113, 1'b1, 1'b1, 2'b01, 1'b1, 5'd2, 1'b0, 1'b0));
    cycle(mk(32'h0010_0193, 1'b1, 1'b1, 2'b01, 1'b1, 5'd3, 1'b0, 1'b0));
    exp_q.delete();
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; instruction = 32'hFFFF_FFFF; stall = 1'b1; flush = 1'b0;
      @(posedge clk); #1;
      chk("stall_valid", 32'(stage_valid), 32'h7);
      chk("stall_rd",    32'(stage_rd),    32'({5'd1, 5'd2, 5'd3}));
      chk("stall_wb_rd", 32'(wb_rd),       32'd1);
      chk("stall_wb_we", 32'(wb_we),       32'd1);
      chk("stall_ill",   32'(illegal),     32'd0);
    end

    // Flush beats stall: stages 0,1 die, stage 2 takes the old stage 1 (x2).
    in_valid = 1'b1; instruction = 32'hFFFF_FFFF; stall = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_valid",  32'(stage_valid), 32'h4);
    chk("flush_we",     32'(stage_we),    32'h4);
    chk("flush_wb_rd",  32'(wb_rd),       32'd2);
    chk("flush_wb_vld", 32'(wb_valid),    32'd1);
    chk("flush_ill",    32'(illegal),     32'd0);

    in_valid = 1'b1; instruction = 32'h0010_0193; stall = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    chk("flush2_valid", 32'(stage_valid), 32'h0);
    chk("flush2_wb",    32'(wb_valid),    32'd0);

    // Mid-stream reset overrides stall and an in-flight illegal pulse.
    flush = 1'b0; stall = 1'b0; in_valid = 1'b1; instruction = 32'h0010_0293;
    repeat (3) @(posedge clk);
    instruction = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("pre_rst_ill",  32'(illegal),  32'd1);
    chk("pre_rst_wb",   32'(wb_valid), 32'd1);
    rst = 1'b0; stall = 1'b1; instruction = 32'h0000_A383;
    @(posedge clk); #1;
    check_zero("midrst");
    rst = 1'b1; in_valid = 1'b0; stall = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/wb_ctl_pipe.md
# wb_ctl_pipe

Parametrised writeback-control pipeline for the rv32 core. It decodes each issued RV32I instruction into writeback select, register-write enable and destination register, then carries that control through STAGES pipeline registers to the writeback port. It also exposes per-stage destination information for hazard logic, flags load-use hazards and illegal encodings, and counts retired register writes. It replaces the single-register writeback decoder: decode moves to issue, and the block adds stall, flush, hazard and retire behaviour.

## Interface
- STAGES, 3, pipeline registers between issue and writeback output (ID/EX, EX/MEM, MEM/WB); legal range 2..8
- FLUSH_DEPTH, 2, number of youngest stages killed by flush; legal range 1..STAGES
- CNT_W, 32, width of the retire counter
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset; sampled on posedge clk
- in_valid  in  1  instruction present at issue
- instruction  in  32  issuing instruction
- stall  in  1  freeze all stages
- flush  in  1  kill the youngest FLUSH_DEPTH stages and the issuing instruction
- stage_valid  out  STAGES  valid bit per stage; bit 0 is youngest
- stage_rd  out  5*STAGES  rd per stage; stage k at bits [5k+4:5k]
- stage_we  out  STAGES  register-write enable per stage
- wb_valid  out  1  last stage holds a valid instruction
- wb_sel  out  2  writeback source: 00 memory, 01 ALU, 10 PC+4
- wb_we  out  1  register-file write enable; never 1 when wb_rd==0
- wb_rd  out  5  destination register
- load_use  out  1  combinational load-use hazard on the issuing instruction
- illegal  out  1  registered, one-cycle pulse on an illegal issue
- retire_cnt  out  CNT_W  count of writebacks with wb_we=1

## Operation
- Decode by opcode:
  - LUI and AUIPC: sel=01, we=1.
  - JAL (1101111) and JALR (1100111, funct3=000): sel=10, we=1.
  - LOAD, funct3 in {000,001,010,100,101}: sel=00, we=1.
  - OP-IMM, OP: sel=01, we=1. SLLI requires funct7=0000000; SRLI/SRAI require funct7 in {0000000,0100000}; OP requires funct7=0000000, or 0100000 only for funct3 000 and 101.
  - Branch (funct3 not 010/011), STORE (funct3 ≤ 010), FENCE, ECALL, EBREAK: sel=00, we=0.
  - Every other encoding is illegal: we=0, sel=00, stage valid=0.
- we is forced to 0 when rd=0. Branch and store rd fields are stored but have we=0.
- load_use = stage_valid[0] & stage 0 is a load & stage_rd[0]≠0 & (rs1 or rs2 of the issuing instruction equals stage_rd[0]) & in_valid. rs2 is compared only for R-type, branch and store. The block only reports load_use; the issue logic stalls on it.
- retire_cnt increments each cycle that wb_valid & wb_we; it wraps from all-ones to 0.

## Timing
- Reset (rst=0 at posedge): all valid, we, rd, sel, illegal and retire_cnt go to 0. Reset overrides stall and flush.
- Issue: with in_valid=1, stall=0 and flush=0, the decoded control enters stage 0 at the next edge. It appears on the wb_* outputs STAGES cycles after the issue edge, with no bubbles when there are no stalls.
- stall=1 with flush=0: every stage holds, and the issuing instruction is not captured. illegal does not pulse.
- flush=1:
  - stages 0..FLUSH_DEPTH-1 load valid=0 and we=0;
  - older stages advance normally, even if stall=1;
  - the issuing instruction is dropped.
  - flush has priority over stall.
- Without stall, the last stage's content retires each cycle and is overwritten by stage STAGES-2.
- illegal pulses for one cycle, at the edge after an unstalled, unflushed in_valid issue of an illegal encoding.
- wb_* and stage_* are registered outputs. Only load_use is combinational.

## Structure
- Shared package wb_pkg holds:
  - opcode localparams (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, FENCE, SYSTEM);
  - WB_MEM=2'b00, WB_ALU=2'b01, WB_PC4=2'b10;
  - a packed typedef wb_ctl_t {valid, we, sel[1:0], rd[4:0]}.
- Sub-module wb_decode: purely combinational, instruction → wb_ctl_t plus illegal. It is reused by the hazard unit.
- The top level holds a generate-loop array of wb_ctl_t stage registers, the flush mask, the load-use comparator and the counter.

## Test plan
- Reset, then issue ADDI x5 with in_valid held: wb_valid=1, wb_sel=01, wb_we=1, wb_rd=5 exactly 3 cycles later; retire_cnt=1 the cycle after.
- Issue JALR x1 (0x000080E7), then SW: the JALR reaches writeback with wb_sel=10, wb_rd=1; the SW reaches writeback with wb_we=0; retire_cnt ends at 1.
- Issue LW x7 followed by ADD x8,x7,x3 in the next cycle: load_use=1 while ADD is issuing. Issue ADD x8,x0,x7 instead with x7≠stage rd: load_use=0.
- Fill three stages, assert stall for 4 cycles: stage contents and wb_* are constant. Then assert flush with stall=1: stages 0 and 1 have valid=0, the stage-2 instruction retires.
- Issue 0xFFFFFFFF, then ADDI x0,x0,0: illegal pulses for one cycle after the first issue. The NOP reaches writeback with wb_valid=1, wb_we=0, and retire_cnt is unchanged.
- Preload retire_cnt near max with CNT_W=4: after 16 writing retirements it returns to its start value. Assert rst=0 mid-stream: all outputs are 0 on the next edge.
